// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, ALU codes, state and instruction-class encodings for the multicycle controller
package rv_ctrl_pkg;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_RR  = 7'b0110011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [2:0] {C_RR, C_IMM, C_LW, C_SW, C_BEQ, C_ILL} cls_t;
  // funct3 to ALU op shared by RR and IMM; SLTU/SLTIU share the SLT code
  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
    return f3 == 3'b000 ? ALU_ADD :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'b110 ? ALU_OR  :
           f3 == 3'b111 ? ALU_AND : ALU_SLT;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational opcode/funct3/funct7 to instruction class and ALU control
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_ctrl,
  output cls_t       o_cls
);
  logic w_f7_zero, w_f7_alt, w_rr_ok, w_imm_ok;
  assign w_f7_zero = i_funct7 == 7'b0000000;
  assign w_f7_alt  = i_funct7 == 7'b0100000;
  assign w_rr_ok   = w_f7_zero | (w_f7_alt & (i_funct3 == 3'b000 | i_funct3 == 3'b101));
  assign w_imm_ok  = i_funct3 == 3'b001 ? w_f7_zero :
                     i_funct3 == 3'b101 ? (w_f7_zero | w_f7_alt) : 1'b1;
  always_comb begin
    o_cls = i_opcode == OP_RR  ? (w_rr_ok ? C_RR : C_ILL) :
            i_opcode == OP_IMM ? (w_imm_ok ? C_IMM : C_ILL) :
            i_opcode == OP_LW  ? C_LW :
            i_opcode == OP_SW  ? C_SW :
            i_opcode == OP_BEQ ? C_BEQ : C_ILL;
    o_alu_ctrl = o_cls == C_RR  ? ((w_f7_alt && i_funct3 == 3'b000) ? ALU_SUB : f3_alu(i_funct3, w_f7_alt)) :
                 o_cls == C_IMM ? f3_alu(i_funct3, w_f7_alt) :
                 o_cls == C_BEQ ? ALU_SUB :
                 (o_cls == C_LW || o_cls == C_SW) ? ALU_ADD : ALU_AND;
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: IF/ID/EX/MEM/WB multicycle control for the RV32I datapath
module mc_control_fsm
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);
  state_t      r_state, w_next;
  cls_t        r_cls, w_cls;
  logic [31:0] r_ir, r_retired;
  logic [3:0]  r_alu, w_alu;
  logic        w_ex, w_mem, w_wb, w_act, w_lw, w_sw, w_beq, w_ill, w_lpc, w_unused;
  alu_decoder u_dec (
    .i_opcode   (r_ir[6:0]),
    .i_funct3   (r_ir[14:12]),
    .i_funct7   (r_ir[31:25]),
    .o_alu_ctrl (w_alu),
    .o_cls      (w_cls)
  );
  assign w_unused = ^{r_ir[24:15], r_ir[11:7]};
  always_ff @(posedge clk)
    if (!rst) r_state <= S_IF;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IF  ? S_ID :
             r_state == S_ID  ? S_EX :
             r_state == S_EX  ? ((r_cls == C_BEQ || r_cls == C_ILL) ? S_IF :
                                 (r_cls == C_LW || r_cls == C_SW) ? S_MEM : S_WB) :
             r_state == S_MEM ? (r_cls == C_LW ? S_WB : S_IF) : S_IF;
  always_ff @(posedge clk)
    if (!rst) begin
      r_ir      <= '0;
      r_cls     <= C_RR;
      r_alu     <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == S_IF) r_ir <= instr;
      if (r_state == S_ID) begin
        r_cls <= w_cls;
        r_alu <= w_alu;
      end
      if (loadPC) r_retired <= r_retired + 32'd1;
    end
  // write strobes are also masked by rst so a reset aborts the in-flight instruction at once
  always_comb begin
    w_ex     = r_state == S_EX;
    w_mem    = r_state == S_MEM;
    w_wb     = r_state == S_WB;
    w_act    = w_ex | w_mem | w_wb;
    w_lw     = r_cls == C_LW;
    w_sw     = r_cls == C_SW;
    w_beq    = r_cls == C_BEQ;
    w_ill    = r_cls == C_ILL;
    w_lpc    = (w_ex & (w_beq | w_ill)) | (w_mem & w_sw) | w_wb;
    ALUSrc   = w_act & (r_cls inside {C_IMM, C_LW, C_SW});
    ALUCtrl  = w_act ? r_alu : 4'b0000;
    loadPC   = rst & w_lpc;
    PCSrc    = w_ex & w_beq & Zero;
    RegWrite = rst & w_wb;
    MemToReg = w_wb & w_lw;
    MemRead  = w_lw & (w_mem | w_wb);
    MemWrite = rst & w_mem & w_sw;
    illegal  = w_ex & w_ill;
    state    = r_state;
    retired  = r_retired;
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed instruction sequence with a per-cycle expected-output scoreboard
module tb_mc_control_fsm;
  logic        clk, rst, Zero;
  logic [31:0] instr;
  logic        ALUSrc, RegWrite, MemToReg, loadPC, PCSrc, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  logic [31:0] retired;
  int          total = 0, bad = 0;
  logic [31:0] exp_ret = 0;
  logic [46:0] sb[$];
  localparam int K_RR = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;
  mc_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .loadPC(loadPC), .PCSrc(PCSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .state(state), .retired(retired)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic push(input logic [2:0] st, input logic as, input logic [3:0] alu,
                      input logic rw, input logic m2r, input logic lpc, input logic pcs,
                      input logic mr, input logic mw, input logic ill);
    sb.push_back({st, as, alu, rw, m2r, lpc, pcs, mr, mw, ill, exp_ret});
    if (lpc) exp_ret = exp_ret + 32'd1;
  endtask
  task automatic check(input string nm, input int n);
    logic [46:0] e, o;
    e = sb.pop_front();
    o = {state, ALUSrc, ALUCtrl, RegWrite, MemToReg, loadPC, PCSrc, MemRead, MemWrite, illegal, retired};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc%0d observed=%h expected=%h", nm, n, o, e);
    end
  endtask
  task automatic exec(input string nm, input logic [31:0] ins, input logic z, input int kind, input logic [3:0] alu);
    logic as;
    int n;
    instr = ins;
    Zero = z;
    #1;
    as = kind == K_IMM || kind == K_LW || kind == K_SW;
    push(3'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    push(3'd1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    push(3'd2, as, alu, 0, 0, kind == K_BEQ || kind == K_ILL, kind == K_BEQ && z, 0, 0, kind == K_ILL);
    if (kind == K_LW) begin
      push(3'd3, 1, alu, 0, 0, 0, 0, 1, 0, 0);
      push(3'd4, 1, alu, 1, 1, 1, 0, 1, 0, 0);
    end
    if (kind == K_SW) push(3'd3, 1, alu, 0, 0, 1, 0, 0, 1, 0);
    if (kind == K_RR || kind == K_IMM) push(3'd4, as, alu, 1, 0, 1, 0, 0, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      check(nm, n);
      n++;
      @(negedge clk);
      #1;
      if (n == 1) instr = ~ins;
    end
  endtask
  initial begin
    rst = 0;
    instr = '0;
    Zero = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    push(3'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    check("reset", 0);
    rst = 1;
    exec("add",  32'h002081B3, 0, K_RR,  4'b0010);
    exec("lw",   32'h0000A183, 0, K_LW,  4'b0010);
    exec("sw",   32'h00112023, 0, K_SW,  4'b0010);
    exec("beq1", 32'h00208463, 1, K_BEQ, 4'b0110);
    exec("beq0", 32'h00208463, 0, K_BEQ, 4'b0110);
    exec("sra",  32'h4020D1B3, 0, K_RR,  4'b1010);
    exec("xor",  32'h0020C1B3, 0, K_RR,  4'b1101);
    exec("addi", 32'h00500093, 0, K_IMM, 4'b0010);
    exec("srai", 32'h4030D093, 0, K_IMM, 4'b1010);
    exec("ill",  32'hFFFFFFFF, 0, K_ILL, 4'b0000);
    exec("slli7", 32'h02109093, 0, K_ILL, 4'b0000);
    exec("rrand7", 32'h4020F1B3, 0, K_ILL, 4'b0000);
    instr = 32'h00112023;
    #1;
    push(3'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    check("swrst", 0);
    @(negedge clk); #1;
    push(3'd1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    check("swrst", 1);
    @(negedge clk); #1;
    push(3'd2, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
    check("swrst", 2);
    @(negedge clk); #1;
    rst = 0;
    #1;
    push(3'd3, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
    check("swrst_mem", 3);
    @(negedge clk); #1;
    exp_ret = 0;
    push(3'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    check("swrst_after", 4);
    rst = 1;
    exec("add2", 32'h002081B3, 0, K_RR, 4'b0010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
